serial_word_driver: RTL and testbench
=====================================

SERIAL_WORD_DRIVER -- requirements
Module: serial_word_driver

Interface
REQ-001 Parameter: MSB, default 4, word width in bits; legal range MSB >= 2.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 load_data  input  MSB  parallel word to serialize; sampled only on an accept edge.
REQ-005 load_dir  input  1  requested shift direction for the downstream bidirectional shift register; sampled on an accept edge.
REQ-006 load_valid  input  1  upstream has a word available.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 data  output  1  serial bit driven to the shift register's data input.
REQ-009 en  output  1  shift enable driven to the shift register's en input.
REQ-010 dir  output  1  direction driven to the shift register's dir input.
REQ-011 busy  output  1  high while a word is being shifted out.
REQ-012 done  output  1  single-cycle pulse after the last bit of a word.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 Accept SHALL occur on a rising edge where load_valid=1 and load_ready=1.
REQ-015 load_ready SHALL be 1 only in IDLE.
REQ-016 On accept, the block SHALL latch load_data into an internal MSB-bit word register, latch load_dir, clear the bit counter, and enter SHIFT.
REQ-017 In SHIFT, en SHALL be 1 and busy SHALL be 1 for exactly MSB consecutive cycles.
REQ-018 The bit counter SHALL count 0..MSB-1, one increment per SHIFT cycle; width SHALL be $clog2(MSB+1).
REQ-019 Bit ordering when latched dir=1 (downstream shifts toward MSB, data enters bit 0): MSB first; bit i of the sequence = word[MSB-1-i].
REQ-020 Bit ordering when latched dir=0 (downstream shifts toward LSB, data enters bit MSB-1): LSB first; bit i of the sequence = word[i].
REQ-021 After the MSB enabled edges, the downstream register SHALL hold exactly the latched word.
REQ-022 After the last SHIFT cycle, the FSM SHALL enter DONE for one cycle, with done=1, en=0 and busy=0; the FSM SHALL then return to IDLE.
REQ-023 dir SHALL equal the latched direction in SHIFT and DONE, and SHALL hold its last value in IDLE.
REQ-024 data SHALL be 0 whenever en=0.
REQ-025 load_valid and load_data changes outside IDLE SHALL be ignored; no word is dropped, and a held request is accepted at the next IDLE cycle.
REQ-026 Back-to-back words SHALL have an en-low gap of exactly 2 cycles (DONE + IDLE).
REQ-027 Outputs en, data, dir, busy, done and load_ready SHALL be decoded only from registered state; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 SHALL dominate all other inputs, including a simultaneous accept.
REQ-029 On a reset edge, the FSM SHALL go to IDLE, the counter and word register SHALL clear, and dir SHALL be 0.
REQ-030 After reset, outputs SHALL be: load_ready=1, en=0, data=0, dir=0, busy=0, done=0.
REQ-031 Reset mid-SHIFT SHALL abort the word; done SHALL NOT pulse, and en SHALL be 0 from the cycle after the reset edge.

Verification (MSB=4; downstream shift register instantiated as the load)
REQ-032 Reset: hold rst=1 for 2 cycles with load_valid=1 -> no accept; load_ready=1, en=0, data=0, dir=0, busy=0, done=0.
REQ-033 MSB-first word: load 4'b1001 with dir=1 -> data=1,0,0,1 over 4 en cycles; done pulses in cycle 5; downstream out=4'b1001.
REQ-034 LSB-first word: load 4'b1101 with dir=0 -> data=1,0,1,1 over 4 en cycles; downstream out=4'b1101; dir=0 throughout.
REQ-035 Request during busy: after accepting 4'b1001, change load_data to 4'b0110 and hold load_valid -> load_ready=0 for 5 cycles; 4'b0110 is accepted in the following IDLE cycle; the first word is shifted intact.
REQ-036 Reset mid-word: assert rst after 2 SHIFT cycles -> en=0 and busy=0 on the next cycle; done never pulses; the next load shifts correctly.
REQ-037 Back-to-back words: hold load_valid=1 continuously with 4'b1010 (dir=1), then 4'b0011 (dir=0) -> exactly 2 en-low cycles between the words; downstream out shows 1010, then 0011.

Source files
------------

// File: rtl/serial_word_driver.sv
// -----------------------------------------------------------------------------
// serial_word_driver
//
// Serializes a parallel MSB-bit word into a downstream bidirectional shift
// register. The shift register is driven through three signals: data, en and
// dir. When dir=1 it shifts toward its MSB and data enters bit 0. When dir=0
// it shifts toward its LSB and data enters bit MSB-1. The driver chooses the
// bit order for each direction so that, after MSB enabled edges, the
// downstream register holds exactly the word that was loaded.
//
// A word is accepted on a rising edge where load_valid and load_ready are
// both 1. It is then shifted out over MSB cycles (SHIFT). One DONE cycle
// follows, and then the block returns to IDLE, where it can accept the next
// word.
//
// Every output comes directly from a flop. The flops are loaded from the
// next-state values, so each output matches a decode of the state register,
// and no input has a combinational path to an output.
//
// Parameters
//   MSB        word width in bits (MSB >= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   load_data  [MSB-1:0] parallel word, sampled on an accept edge
//   load_dir   requested downstream shift direction, sampled on accept
//   load_valid upstream has a word available
//   load_ready high only in IDLE: the block can take a word this cycle
//   data       serial bit to the shift register (0 whenever en=0)
//   en         shift enable to the shift register
//   dir        direction to the shift register (held in IDLE)
//   busy       high while a word is being shifted out
//   done       one-cycle pulse after the last bit of a word
// -----------------------------------------------------------------------------
module serial_word_driver #(
    parameter int MSB = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [MSB-1:0] load_data,
    input  logic           load_dir,
    input  logic           load_valid,
    output logic           load_ready,
    output logic           data,
    output logic           en,
    output logic           dir,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(MSB + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(MSB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [MSB-1:0] word_r;
    logic [MSB-1:0] word_nxt_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nxt_s;
    logic           dir_r;
    logic           dir_nxt_s;

    logic           load_ready_r;
    logic           data_r;
    logic           en_r;
    logic           busy_r;
    logic           done_r;

    logic           load_ready_nxt_s;
    logic           data_nxt_s;
    logic           en_nxt_s;
    logic           busy_nxt_s;
    logic           done_nxt_s;

    // Select the bit presented on shift step idx.
    // MSB-first (dir=1) walks word[MSB-1] down to word[0].
    // LSB-first (dir=0) walks word[0] up to word[MSB-1].
    // A compare loop is used so the index needs no width conversion.
    function automatic logic pick_bit(input logic [MSB-1:0] w,
                                      input logic [CW-1:0]  idx,
                                      input logic           msb_first);
        logic [CW-1:0] pos;
        logic          b;
        b = 1'b0;
        if (msb_first) begin
            pos = LAST_BIT - idx;
        end else begin
            pos = idx;
        end
        for (int i = 0; i < MSB; i++) begin
            if (pos == CW'(i)) begin
                b = w[i];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // Next-state, datapath and output decode for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        word_nxt_s  = word_r;
        cnt_nxt_s   = cnt_r;
        dir_nxt_s   = dir_r;

        case (state_r)
            IDLE: begin
                // load_ready is 1 in IDLE, so load_valid alone qualifies an accept.
                if (load_valid) begin
                    word_nxt_s  = load_data;
                    dir_nxt_s   = load_dir;
                    cnt_nxt_s   = {CW{1'b0}};
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                // The counter stops at MSB-1; the last step moves the FSM to DONE.
                if (cnt_r == LAST_BIT) begin
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + CW'(1);
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Outputs for the next cycle, decoded from the next register contents.
        load_ready_nxt_s = (state_nxt_s == IDLE);
        en_nxt_s         = (state_nxt_s == SHIFT);
        busy_nxt_s       = (state_nxt_s == SHIFT);
        done_nxt_s       = (state_nxt_s == DONE);
        if (en_nxt_s) begin
            data_nxt_s = pick_bit(word_nxt_s, cnt_nxt_s, dir_nxt_s);
        end else begin
            data_nxt_s = 1'b0;
        end
    end

    // State, datapath and registered outputs; rst overrides any accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            word_r       <= {MSB{1'b0}};
            cnt_r        <= {CW{1'b0}};
            dir_r        <= 1'b0;
            load_ready_r <= 1'b1;
            data_r       <= 1'b0;
            en_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            word_r       <= word_nxt_s;
            cnt_r        <= cnt_nxt_s;
            dir_r        <= dir_nxt_s;
            load_ready_r <= load_ready_nxt_s;
            data_r       <= data_nxt_s;
            en_r         <= en_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign load_ready = load_ready_r;
    assign data       = data_r;
    assign en         = en_r;
    assign dir        = dir_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_serial_word_driver.sv
// -----------------------------------------------------------------------------
// tb_serial_word_driver
//
// Test bench for serial_word_driver with MSB=4. A behavioural model of the
// downstream bidirectional shift register is the load.
//
// When a word is accepted, the expected serial bits and the expected final
// word are pushed to queues. On every falling edge the monitor pops these
// queues and checks data/dir while en is high. It also checks the downstream
// register when done pulses.
//
// Directed sequences cover:
//   - reset
//   - MSB-first and LSB-first words
//   - a request held while the block is busy
//   - reset in the middle of a word
//   - back-to-back words
// -----------------------------------------------------------------------------
module tb_serial_word_driver;

    logic       clk;
    logic       rst;
    logic [3:0] load_data;
    logic       load_dir;
    logic       load_valid;
    logic       load_ready;
    logic       data;
    logic       en;
    logic       dir;
    logic       busy;
    logic       done;

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [3:0] ds = 4'b0000;
    logic [1:0] bitq[$];
    logic [4:0] wordq[$];
    logic [1:0] e_bit;
    logic [4:0] e_word;
    logic       prev_en   = 1'b0;
    int         low_run   = 0;
    int         last_gap  = -1;
    bit         mon_on    = 1'b0;

    serial_word_driver #(.MSB(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_dir   (load_dir),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data       (data),
        .en         (en),
        .dir        (dir),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream bidirectional shift register model.
    always @(posedge clk) begin
        if (en === 1'b1) begin
            if (dir) ds <= {ds[2:0], data};
            else     ds <= {data, ds[3:1]};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compare on falling edges, push on upcoming accepts.
    always @(negedge clk) begin
        if (mon_on) begin
            if (en) begin
                if (bitq.size() == 0) begin
                    check_val("unexpected_en", 32'd1, 32'd0);
                end else begin
                    e_bit = bitq.pop_front();
                    check_val("data_bit", {31'd0, data}, {31'd0, e_bit[0]});
                    check_val("dir_shift", {31'd0, dir}, {31'd0, e_bit[1]});
                end
                if (!prev_en) last_gap = low_run;
                low_run = 0;
            end else begin
                check_val("data_when_idle", {31'd0, data}, 32'd0);
                low_run++;
            end
            if (done) begin
                if (wordq.size() == 0) begin
                    check_val("spurious_done", 32'd1, 32'd0);
                end else begin
                    e_word = wordq.pop_front();
                    check_val("ds_word", {28'd0, ds}, {28'd0, e_word[3:0]});
                    check_val("dir_done", {31'd0, dir}, {31'd0, e_word[4]});
                    check_val("done_after_last", {31'd0, prev_en}, 32'd1);
                    check_val("bits_left_at_done", bitq.size(), 32'd0);
                end
            end
            prev_en = en;
            if (rst) begin
                bitq.delete();
                wordq.delete();
            end else if (load_valid && load_ready) begin
                for (int i = 0; i < 4; i++) begin
                    bitq.push_back({load_dir, load_dir ? load_data[3-i] : load_data[i]});
                end
                wordq.push_back({load_dir, load_data});
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!load_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!load_ready) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_word(input logic [3:0] w, input logic d);
        load_data  = w;
        load_dir   = d;
        load_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    // Count falling edges after the accept edge until done is seen.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;

        // Reset held for several edges while a request is presented.
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'b1111;
        load_dir   = 1'b1;
        repeat (2) @(posedge clk);
        #1 mon_on = 1'b1;
        @(negedge clk);
        check_val("rst_ready", {31'd0, load_ready}, 32'd1);
        check_val("rst_en",    {31'd0, en},         32'd0);
        check_val("rst_data",  {31'd0, data},       32'd0);
        check_val("rst_dir",   {31'd0, dir},        32'd0);
        check_val("rst_busy",  {31'd0, busy},       32'd0);
        check_val("rst_done",  {31'd0, done},       32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", {31'd0, load_ready}, 32'd1);
        check_val("post_rst_busy",  {31'd0, busy},       32'd0);

        // MSB-first word.
        drive_word(4'b1001, 1'b1);
        wait_done(n);
        check_val("msb_done_latency", n, 32'd5);
        check_val("msb_ds", {28'd0, ds}, 32'h9);
        @(negedge clk);
        check_val("idle_dir_hold", {31'd0, dir},        32'd1);
        check_val("idle_ready",    {31'd0, load_ready}, 32'd1);
        check_val("idle_done",     {31'd0, done},       32'd0);

        // LSB-first word.
        @(posedge clk);
        #1 drive_word(4'b1101, 1'b0);
        wait_done(n);
        check_val("lsb_done_latency", n, 32'd5);
        check_val("lsb_ds", {28'd0, ds}, 32'hd);
        check_val("lsb_dir", {31'd0, dir}, 32'd0);

        // Request held while busy; the data change must not corrupt word one.
        @(posedge clk);
        #1;
        load_data  = 4'b1001;
        load_dir   = 1'b1;
        load_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 load_data = 4'b0110;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (load_ready) break;
            cnt++;
        end
        check_val("busy_ready_low_cycles", cnt, 32'd5);
        @(posedge clk);
        #1 load_valid = 1'b0;
        wait_done(n);
        check_val("held_done_latency", n, 32'd5);
        check_val("held_ds", {28'd0, ds}, 32'h6);

        // Reset after two SHIFT cycles.
        @(posedge clk);
        #1 drive_word(4'b0101, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort_en",    {31'd0, en},         32'd0);
        check_val("abort_busy",  {31'd0, busy},       32'd0);
        check_val("abort_done",  {31'd0, done},       32'd0);
        check_val("abort_ready", {31'd0, load_ready}, 32'd1);
        check_val("abort_dir",   {31'd0, dir},        32'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check_val("abort_no_done", cnt, 32'd0);
        @(posedge clk);
        #1 drive_word(4'b0110, 1'b0);
        wait_done(n);
        check_val("after_abort_latency", n, 32'd5);
        check_val("after_abort_ds", {28'd0, ds}, 32'h6);

        // Back-to-back words with load_valid held continuously.
        @(posedge clk);
        #1;
        load_data  = 4'b1010;
        load_dir   = 1'b1;
        load_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        load_data = 4'b0011;
        load_dir  = 1'b0;
        wait_ready();
        @(posedge clk);
        #1 load_valid = 1'b0;
        wait_done(n);
        check_val("b2b_done_latency", n, 32'd5);
        check_val("b2b_gap", last_gap, 32'd2);
        check_val("b2b_ds", {28'd0, ds}, 32'h3);

        repeat (3) @(negedge clk);
        check_val("bitq_drained",  bitq.size(),  32'd0);
        check_val("wordq_drained", wordq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
